// File: rtl/adder_bist_if.sv
// rtl/adder_bist_if.sv - operand/result bus between the BIST engine and the adder under test
interface adder_bist_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             cin_out;
    logic [WIDTH-1:0] sum_in;
    logic             cout_in;

    modport master (output a_out, b_out, cin_out, input sum_in, cout_in);
    modport slave  (input a_out, b_out, cin_out, output sum_in, cout_in);
endinterface

// File: rtl/adder_bist.sv
// rtl/adder_bist.sv - built-in self-test engine for a ripple-carry adder stage
module adder_bist #(
    parameter int          WIDTH     = 4,
    parameter int          SETTLE    = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [15:0]        rand_count,
    adder_bist_if.master       bus,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        err_count,
    output logic [15:0]        vec_count,
    output logic [2*WIDTH:0]   first_fail,
    output logic [WIDTH:0]     first_got,
    output logic               first_fail_valid
);
    localparam int VW = 2 * WIDTH + 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [VW-1:0] VEC_LAST    = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [VW-1:0]   vec;
    logic [15:0]     lfsr;
    logic [SW-1:0]   settle;
    logic            mode_r;
    logic [15:0]     target;

    logic            accept;
    logic            sample;
    logic [15:0]     lfsr_step;
    logic [WIDTH:0]  ideal;
    logic [WIDTH:0]  got;
    logic            mismatch;
    logic [15:0]     err_next;
    logic            last_vec;

    // V = {a, b, cin} with cin as the LSB
    assign bus.a_out   = vec[VW-1 -: WIDTH];
    assign bus.b_out   = vec[WIDTH:1];
    assign bus.cin_out = vec[0];

    assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign ideal     = {1'b0, bus.a_out} + {1'b0, bus.b_out} + {{WIDTH{1'b0}}, bus.cin_out};
    assign got       = {bus.cout_in, bus.sum_in};
    assign mismatch  = (got != ideal);
    assign err_next  = (mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
    assign last_vec  = mode_r ? (vec_count + 16'd1 == target) : (vec == VEC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        sample     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (mode && rand_count == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (settle == '0) begin
                    sample = 1'b1;
                    if (last_vec) state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec              <= '0;
            lfsr             <= LFSR_SEED;
            settle           <= '0;
            mode_r           <= 1'b0;
            target           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            vec_count        <= '0;
            first_fail       <= '0;
            first_got        <= '0;
            first_fail_valid <= 1'b0;
        end else if (accept) begin
            err_count        <= '0;
            vec_count        <= '0;
            first_fail       <= '0;
            first_got        <= '0;
            first_fail_valid <= 1'b0;
            mode_r           <= mode;
            target           <= rand_count;
            settle           <= SETTLE_LOAD;
            lfsr             <= LFSR_SEED;
            vec              <= mode ? VW'(LFSR_SEED) : '0;
            // an empty random run completes without ever raising busy
            if (state_next == DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= 1'b1;
            end else begin
                busy <= 1'b1;
                done <= 1'b0;
                pass <= 1'b0;
            end
        end else if (state == RUN) begin
            if (!sample) begin
                settle <= settle - SW'(1);
            end else begin
                err_count <= err_next;
                vec_count <= vec_count + 16'd1;
                if (mismatch && !first_fail_valid) begin
                    first_fail       <= vec;
                    first_got        <= got;
                    first_fail_valid <= 1'b1;
                end
                if (last_vec) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_next == 16'd0);
                end else begin
                    settle <= SETTLE_LOAD;
                    if (mode_r) begin
                        lfsr <= lfsr_step;
                        vec  <= VW'(lfsr_step);
                    end else begin
                        vec  <= vec + VW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_bist.sv
// tb/tb_adder_bist.sv - directed bench for adder_bist with correct, stuck-at and slow adder models
module tb_adder_bist;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_d = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] rand_count = 16'd0;
    logic        fault = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // u0: SETTLE=2, combinational adder with optional SUM[0] stuck-at-0
    adder_bist_if #(.WIDTH(4)) bus0();
    logic        busy0, done0, pass0, ffv0;
    logic [15:0] err0, vec0;
    logic [8:0]  ff0;
    logic [4:0]  fg0;
    logic [4:0]  true0;
    assign true0        = {1'b0, bus0.a_out} + {1'b0, bus0.b_out} + {4'd0, bus0.cin_out};
    assign bus0.sum_in  = fault ? (true0[3:0] & 4'b1110) : true0[3:0];
    assign bus0.cout_in = true0[4];

    adder_bist #(.WIDTH(4), .SETTLE(2), .LFSR_SEED(16'hACE1)) u0 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .rand_count(rand_count),
        .bus(bus0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .vec_count(vec0), .first_fail(ff0), .first_got(fg0), .first_fail_valid(ffv0));

    // u1 (SETTLE=1) and u2 (SETTLE=4) both drive an adder with 3 cycles of output delay
    adder_bist_if #(.WIDTH(4)) bus1();
    adder_bist_if #(.WIDTH(4)) bus2();
    logic        busy1, done1, pass1, ffv1, busy2, done2, pass2, ffv2;
    logic [15:0] err1, vec1, err2, vec2;
    logic [8:0]  ff1, ff2;
    logic [4:0]  fg1, fg2;
    logic [4:0]  p1a = 5'd0, p1b = 5'd0, p1c = 5'd0;
    logic [4:0]  p2a = 5'd0, p2b = 5'd0, p2c = 5'd0;

    always @(posedge clk) begin
        p1a <= {1'b0, bus1.a_out} + {1'b0, bus1.b_out} + {4'd0, bus1.cin_out};
        p1b <= p1a;
        p1c <= p1b;
        p2a <= {1'b0, bus2.a_out} + {1'b0, bus2.b_out} + {4'd0, bus2.cin_out};
        p2b <= p2a;
        p2c <= p2b;
    end
    assign bus1.sum_in  = p1c[3:0];
    assign bus1.cout_in = p1c[4];
    assign bus2.sum_in  = p2c[3:0];
    assign bus2.cout_in = p2c[4];

    adder_bist #(.WIDTH(4), .SETTLE(1), .LFSR_SEED(16'hACE1)) u1 (
        .clk(clk), .rst(rst), .start(start_d), .mode(mode), .rand_count(rand_count),
        .bus(bus1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .vec_count(vec1), .first_fail(ff1), .first_got(fg1), .first_fail_valid(ffv1));

    adder_bist #(.WIDTH(4), .SETTLE(4), .LFSR_SEED(16'hACE1)) u2 (
        .clk(clk), .rst(rst), .start(start_d), .mode(mode), .rand_count(rand_count),
        .bus(bus2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .vec_count(vec2), .first_fail(ff2), .first_got(fg2), .first_fail_valid(ffv2));

    typedef struct {
        logic        flt;
        logic        md;
        logic [15:0] rc;
        int          cyc;
        int          err;
        int          vec;
        logic        pass;
        logic        ffv;
        logic [8:0]  ff;
        logic [4:0]  fg;
    } row_t;

    row_t tbl[4];

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pulse(input logic on_d);
        @(negedge clk);
        if (on_d) start_d = 1'b1;
        else      start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        start_d = 1'b0;
    endtask

    task automatic wait_u0(output int cyc);
        cyc = 0;
        while (busy0 && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int          cyc;
        int          m_err;
        logic        m_first;
        logic [8:0]  m_ff;
        logic [4:0]  m_fg;
        logic [15:0] m;
        logic [8:0]  v;
        logic [4:0]  s;

        // reference for a random run through the stuck-at adder
        m = 16'hACE1; m_err = 0; m_first = 1'b0; m_ff = '0; m_fg = '0;
        for (int i = 0; i < 100; i++) begin
            v = m[8:0];
            s = {1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'd0, v[0]};
            if (s[0]) begin
                m_err++;
                if (!m_first) begin
                    m_first = 1'b1;
                    m_ff    = v;
                    m_fg    = s & 5'h1E;
                end
            end
            m = {m[14:0], ^(m & 16'hB400)};
        end

        tbl[0] = '{1'b0, 1'b0, 16'd0,   1024, 0,     512, 1'b1,           1'b0,    9'h000, 5'h00};
        tbl[1] = '{1'b1, 1'b0, 16'd0,   1024, 256,   512, 1'b0,           1'b1,    9'h001, 5'h00};
        tbl[2] = '{1'b0, 1'b1, 16'd100, 200,  0,     100, 1'b1,           1'b0,    9'h000, 5'h00};
        tbl[3] = '{1'b1, 1'b1, 16'd100, 200,  m_err, 100, (m_err == 0),   m_first, m_ff,   m_fg};

        #23;
        check("reset_busy", busy0, 0);
        check("reset_done", done0, 0);
        check("reset_a", bus0.a_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_vec", vec0, 0);
        check("idle_pass", pass0, 0);

        for (int r = 0; r < 4; r++) begin
            fault      = tbl[r].flt;
            mode       = tbl[r].md;
            rand_count = tbl[r].rc;
            pulse(1'b0);
            check($sformatf("row%0d_busy_start", r), busy0, 1);
            check($sformatf("row%0d_done_clr", r), done0, 0);
            if (r == 2) begin
                check("rand_first_a", bus0.a_out, 7);
                check("rand_first_b", bus0.b_out, 0);
                check("rand_first_cin", bus0.cin_out, 1);
            end
            wait_u0(cyc);
            check($sformatf("row%0d_busy_cycles", r), cyc, tbl[r].cyc);
            check($sformatf("row%0d_done", r), done0, 1);
            check($sformatf("row%0d_pass", r), pass0, tbl[r].pass);
            check($sformatf("row%0d_err", r), err0, tbl[r].err);
            check($sformatf("row%0d_vec", r), vec0, tbl[r].vec);
            check($sformatf("row%0d_ffv", r), ffv0, tbl[r].ffv);
            check($sformatf("row%0d_ff", r), ff0, tbl[r].ff);
            check($sformatf("row%0d_fg", r), fg0, tbl[r].fg);
        end

        // empty random run: done immediately, busy never high
        fault = 1'b0; mode = 1'b1; rand_count = 16'd0;
        pulse(1'b0);
        check("empty_done", done0, 1);
        check("empty_pass", pass0, 1);
        check("empty_busy", busy0, 0);
        check("empty_vec", vec0, 0);
        @(posedge clk);
        #1;
        check("empty_busy_later", busy0, 0);

        // asynchronous reset in the middle of a faulty exhaustive run
        fault = 1'b1; mode = 1'b0;
        pulse(1'b0);
        repeat (400) @(posedge clk);
        #1;
        check("mid_vec", vec0, 200);
        check("mid_ffv", ffv0, 1);
        #3;
        rst = 1'b1;
        #1;
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_err", err0, 0);
        check("rst_vec", vec0, 0);
        check("rst_ffv", ffv0, 0);
        check("rst_ff", ff0, 0);
        check("rst_fg", fg0, 0);
        check("rst_ab", {bus0.a_out, bus0.b_out, bus0.cin_out}, 0);
        @(negedge clk);
        rst   = 1'b0;
        fault = 1'b0;
        pulse(1'b0);
        wait_u0(cyc);
        check("post_rst_cycles", cyc, 1024);
        check("post_rst_vec", vec0, 512);
        check("post_rst_pass", pass0, 1);

        // start while running is ignored
        pulse(1'b0);
        cyc = 0;
        while (vec0 != 16'd50 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("reach_vec50", vec0, 50);
        pulse(1'b0);
        check("busy_start_vec", vec0 >= 16'd50, 1);
        check("busy_start_busy", busy0, 1);
        wait_u0(cyc);
        check("busy_start_final_vec", vec0, 512);
        check("busy_start_done", done0, 1);

        // start from DONE restarts
        pulse(1'b0);
        check("restart_done_clr", done0, 0);
        check("restart_busy", busy0, 1);
        check("restart_vec", vec0, 0);
        wait_u0(cyc);
        check("restart_cycles", cyc, 1024);
        check("restart_pass", pass0, 1);

        // settle window against a 3-cycle-latency adder
        mode = 1'b0;
        pulse(1'b1);
        cyc = 0;
        while ((busy1 || busy2) && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("slow_cycles", cyc, 2048);
        check("settle1_err_nonzero", err1 != 16'd0, 1);
        check("settle1_pass", pass1, 0);
        check("settle1_vec", vec1, 512);
        check("settle4_err", err2, 0);
        check("settle4_pass", pass2, 1);
        check("settle4_vec", vec2, 512);
        check("settle4_ffv", ffv2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adder_bist.md
# adder_bist

- Synthesizable built-in self-test engine for the ripple-carry adder stage.
- Sits on both sides of the adder: it drives `a_out`, `b_out` and `cin_out` into the adder, then samples the adder's `{cout_in, sum_in}` after a programmable settle time.
- It compares the sampled result against an internal ideal sum, counts mismatches and latches the first failing vector.
- Supports exhaustive sweep and LFSR pseudo-random modes, so adder checks run on silicon/FPGA and in simulation without a testbench-side golden model.

## Interface
Parameters:
- `WIDTH`, 4, adder operand width.
- `SETTLE`, 2, clock cycles each vector is held before sampling; must be ≥1.
- `LFSR_SEED`, 16'hACE1, non-zero reset/start seed for random mode.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse that begins a run; honoured only in IDLE or DONE.
- `mode`  in  1  0 = exhaustive, 1 = pseudo-random; sampled at start.
- `rand_count`  in  16  number of vectors in random mode; sampled at start.
- `a_out`, `b_out`  out  WIDTH  operands to the adder.
- `cin_out`  out  1  carry-in to the adder.
- `sum_in`  in  WIDTH  adder sum.
- `cout_in`  in  1  adder carry-out.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until the next accepted start.
- `pass`  out  1  valid when done; 1 iff `err_count`==0.
- `err_count`  out  16  mismatch count, saturating at 16'hFFFF.
- `vec_count`  out  16  vectors checked in the current/last run.
- `first_fail`  out  2*WIDTH+1  `{a,b,cin}` of the first mismatch.
- `first_got`  out  WIDTH+1  observed `{cout,sum}` at the first mismatch.
- `first_fail_valid`  out  1  `first_fail`/`first_got` hold a captured mismatch.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **Vector word** V = `{a_out, b_out, cin_out}`, 2*WIDTH+1 bits, with `cin_out` as the LSB.
- **Exhaustive mode:** V starts at 0 and increments by 1 per vector. The last vector is all-ones, giving 2^(2*WIDTH+1) vectors in total (512 for WIDTH=4).
- **Random mode:** 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, loaded with `LFSR_SEED` at start.
  - V = LFSR[2*WIDTH:0]; the LFSR advances once per vector.
  - Runs `rand_count` vectors. WIDTH ≤ 7 is required for random mode.
- **IDLE/DONE + start:**
  - Clear `err_count`, `vec_count`, `first_*` and `done`.
  - Load the first vector and a settle counter of SETTLE-1.
  - Set `busy`=1 and go to RUN.
  - Exception: random mode with `rand_count`=0 goes straight to DONE with `pass`=1 and `busy` never asserted.
- **RUN:** decrement the settle counter. When it reads 0:
  - Compare `{cout_in,sum_in}` against `a_out + b_out + cin_out`, computed WIDTH+1 bits wide.
  - On mismatch, increment `err_count` (saturating). If `first_fail_valid`=0, capture V and the observed value and set `first_fail_valid`.
  - Increment `vec_count`.
  - If this was the last vector: go to DONE, set `busy`=0, `done`=1, `pass`=(final `err_count`==0). Else drive the next vector and reload the settle counter.
- **DONE:** outputs hold, including the last vector on `a/b/cin_out`.
- **start while RUN:** ignored.
- **Reset values:** every output, the state and all counters are 0 (IDLE), except the LFSR, which resets to `LFSR_SEED`.
- **rst during RUN:** the run aborts immediately (asynchronous). No partial results are retained.

## Timing
- **Vector timing:** a vector is driven at edge E and sampled at edge E+SETTLE. The next vector is driven on that same edge, so the throughput is one vector per SETTLE cycles.
- **busy length:** with start accepted at edge 0, `busy` is high for N*SETTLE cycles. `done`, `pass` and the final counts update on edge N*SETTLE.
- **Combinational adder path:** `sum_in`/`cout_in` must settle within SETTLE clock periods of the vector changing. Registered adders need SETTLE > their latency.
- **Mismatch capture:** the capture and the `err_count` increment are visible the cycle after the sampling edge, registered with the sample.

## Test plan
- **Exhaustive, correct adder:** WIDTH=4, SETTLE=2, correct combinational adder, `mode`=0, start → `busy` high for 1024 cycles; then `done`=1, `pass`=1, `err_count`=0, `vec_count`=512, `first_fail_valid`=0.
- **Exhaustive, stuck-at fault:** adder with SUM[0] stuck at 0, exhaustive → `err_count`=256, `first_fail`=9'h001, `first_got`=5'h00, `pass`=0.
- **Random mode:** `mode`=1, `rand_count`=100, SETTLE=2, start → `done` after 200 cycles with `vec_count`=100. With `rand_count`=0 → `done`=1 and `pass`=1 one cycle after start, `busy` never high.
- **Settle window:** adder model with a 3-cycle output delay. SETTLE=1 → `err_count`>0, `pass`=0. SETTLE=4 → `pass`=1.
- **Reset mid-run:** assert `rst` after 200 vectors → all outputs 0 immediately, state IDLE. A following start completes a clean 512-vector run with `pass`=1.
- **start while busy:** pulse `start` at vector 50 → ignored; the run still ends with `vec_count`=512. A start pulse in DONE clears `done` and restarts.
